tone_synth: RTL and testbench

TONE_SYNTH -- requirements
Module: tone_synth

---
 rtl/tone_synth.sv | 154 +++++++++++++++
 tb/tb_tone_synth.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// Keyboard tone synthesizer: 24-bit phase accumulator square wave scaled by an envelope level.
// Define TONE_SYNTH_ENVELOPE_EN for the ATTACK/SUSTAIN/RELEASE envelope; otherwise the level gates 0/255.
module tone_synth #(
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2,
    parameter int AMP_STEP     = 390625
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        key_down,
    input  logic [3:0]  note_code,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [1:0]  env_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_t;

    logic               wr_q, wr_d;
    logic               key_q, key_d;
    logic               rise_pend_q, rise_pend_d;
    logic               fall_pend_q, fall_pend_d;
    logic [3:0]         note_q, note_d;
    env_t               state_q, state_d;
    logic [7:0]         level_q, level_d;
    logic [23:0]        phase_q, phase_d;
    logic signed [31:0] sample_q, sample_d;

    logic rise_now, fall_now, rise_eff, fall_eff;

    // Phase increment per 48 kHz sample, equal temperament C4..B4; rest codes do not advance.
    function automatic logic [23:0] note_inc(input logic [3:0] n);
        case (n)
            4'd0:    note_inc = 24'd91445;
            4'd1:    note_inc = 24'd96882;
            4'd2:    note_inc = 24'd102643;
            4'd3:    note_inc = 24'd108747;
            4'd4:    note_inc = 24'd115213;
            4'd5:    note_inc = 24'd122064;
            4'd6:    note_inc = 24'd129322;
            4'd7:    note_inc = 24'd137012;
            4'd8:    note_inc = 24'd145160;
            4'd9:    note_inc = 24'd153791;
            4'd10:   note_inc = 24'd162936;
            4'd11:   note_inc = 24'd172625;
            default: note_inc = 24'd0;
        endcase
    endfunction

    function automatic logic [7:0] level_up(input logic [7:0] lvl);
        logic [8:0] sum;
        sum = {1'b0, lvl} + 9'(ATTACK_STEP);
        level_up = (sum >= 9'd255) ? 8'd255 : sum[7:0];
    endfunction

    function automatic logic [7:0] level_down(input logic [7:0] lvl);
        level_down = (lvl <= 8'(RELEASE_STEP)) ? 8'd0 : lvl - 8'(RELEASE_STEP);
    endfunction

    function automatic logic signed [31:0] make_sample(input logic [7:0] lvl,
                                                       input logic       neg,
                                                       input logic       mute);
        logic [31:0] mag;
        mag = 32'(lvl) * 32'(AMP_STEP);
        if (mute)
            make_sample = '0;
        else if (neg)
            make_sample = -$signed(mag);
        else
            make_sample = $signed(mag);
    endfunction

    always_comb begin
        wr_d     = audio_out_allowed & ~wr_q;
        key_d    = key_down;
        rise_now = key_down & ~key_q;
        fall_now = ~key_down & key_q;
        // Edges seen between writes collapse to the most recent one.
        rise_eff = rise_now | (rise_pend_q & ~fall_now);
        fall_eff = fall_now | (fall_pend_q & ~rise_now);
        note_d   = rise_now ? note_code : note_q;

        rise_pend_d = rise_eff;
        fall_pend_d = fall_eff;
        state_d     = state_q;
        level_d     = level_q;
        phase_d     = phase_q;
        sample_d    = sample_q;

        if (wr_q) begin
            rise_pend_d = 1'b0;
            fall_pend_d = 1'b0;
            if (state_q == IDLE)
                phase_d = rise_eff ? 24'd0 : phase_q;
            else
                phase_d = phase_q + note_inc(note_d);
`ifdef TONE_SYNTH_ENVELOPE_EN
            if (rise_eff || (state_q == ATTACK && !fall_eff)) begin
                level_d = level_up(level_q);
                state_d = (level_d == 8'd255) ? SUSTAIN : ATTACK;
            end else if (state_q == RELEASE || (fall_eff && state_q != IDLE)) begin
                level_d = level_down(level_q);
                state_d = (level_d == 8'd0) ? IDLE : RELEASE;
            end
`else
            if (rise_eff) begin
                level_d = 8'd255;
                state_d = SUSTAIN;
            end else if (fall_eff && state_q != IDLE) begin
                level_d = 8'd0;
                state_d = IDLE;
            end
`endif
            sample_d = make_sample(level_d, phase_d[23], note_d >= 4'd12);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_q        <= 1'b0;
            key_q       <= 1'b0;
            rise_pend_q <= 1'b0;
            fall_pend_q <= 1'b0;
            note_q      <= 4'd12;
            state_q     <= IDLE;
            level_q     <= 8'd0;
            phase_q     <= 24'd0;
            sample_q    <= '0;
        end else begin
            wr_q        <= wr_d;
            key_q       <= key_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            note_q      <= note_d;
            state_q     <= state_d;
            level_q     <= level_d;
            phase_q     <= phase_d;
            sample_q    <= sample_d;
        end
    end

    assign write_audio_out         = wr_q;
    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign env_state               = state_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth; expectations adapt to TONE_SYNTH_ENVELOPE_EN.
module tb_tone_synth;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_down;
    logic [3:0]  note_code;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic [1:0]  env_state;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [23:0] ph;
    logic [23:0] inc;

    localparam int PH_ADV  = 0;
    localparam int PH_CLR  = 1;
    localparam int PH_HOLD = 2;

    tone_synth dut (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .key_down                (key_down),
        .note_code               (note_code),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .env_state               (env_state)
    );

    always #10 clk = ~clk;

    function automatic int att_lvl(input int base, input int k);
`ifdef TONE_SYNTH_ENVELOPE_EN
        return (base + 8 * k > 255) ? 255 : base + 8 * k;
`else
        return 255;
`endif
    endfunction

    function automatic int att_st(input int base, input int k);
`ifdef TONE_SYNTH_ENVELOPE_EN
        return (att_lvl(base, k) == 255) ? 2 : 1;
`else
        return 2;
`endif
    endfunction

    function automatic int rel_lvl(input int base, input int j);
        if (j == 0) return base;
`ifdef TONE_SYNTH_ENVELOPE_EN
        return (base - 2 * j < 0) ? 0 : base - 2 * j;
`else
        return 0;
`endif
    endfunction

    function automatic int rel_st(input int base, input int j);
        return (rel_lvl(base, j) == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Waits for the next strobe, then checks the sample registered by that write.
    task automatic wr_check(input int lvl, input int st, input int pmode, input string tag);
        logic               got;
        logic signed [31:0] expv;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (write_audio_out === 1'b1) got = 1'b1;
        end
        chk({tag, "_strobe"}, {31'd0, got}, 32'd1);
        if (pmode == PH_CLR) ph = 24'd0;
        else if (pmode == PH_ADV) ph = ph + inc;
        expv = lvl * 390625;
        if (ph[23]) expv = -expv;
        @(negedge clk);
        chk({tag, "_left"}, left_out, expv);
        chk({tag, "_right"}, right_out, expv);
        chk({tag, "_state"}, {30'd0, env_state}, st);
    endtask

    initial begin
        logic        prev;
        logic        strobed, moved, got;
        logic [31:0] held;
        int          base;

        ph = 24'd0;
        inc = 24'd153791;
        reset = 1'b1;
        key_down = 1'b0;
        note_code = 4'd0;
        audio_out_allowed = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_write", {31'd0, write_audio_out}, 32'd0);
        chk("rst_left", left_out, 32'd0);
        chk("rst_right", right_out, 32'd0);
        chk("rst_state", {30'd0, env_state}, 32'd0);
        reset = 1'b0;

        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("alternate", {31'd0, write_audio_out}, {31'd0, ~prev});
            prev = write_audio_out;
        end
        wr_check(0, 0, PH_HOLD, "idle0");
        wr_check(0, 0, PH_HOLD, "idle1");

        // Press A4; note change while held must be ignored.
        note_code = 4'd9;
        key_down = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            wr_check(att_lvl(0, k), att_st(0, k), (k == 1) ? PH_CLR : PH_ADV, "attack");
            if (k == 5) note_code = 4'd0;
        end

        audio_out_allowed = 1'b0;
        held = left_out;
        strobed = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (write_audio_out !== 1'b0) strobed = 1'b1;
            if (left_out !== held) moved = 1'b1;
        end
        chk("freeze_strobe", {31'd0, strobed}, 32'd0);
        chk("freeze_hold", {31'd0, moved}, 32'd0);
        audio_out_allowed = 1'b1;
        wr_check(255, 2, PH_ADV, "unfreeze");

        key_down = 1'b0;
        for (int j = 1; j <= 130; j++)
            wr_check(rel_lvl(255, j), rel_st(255, j),
                     (rel_lvl(255, j - 1) > 0) ? PH_ADV : PH_HOLD, "release");

        // Re-press during release at level 100 (envelope build).
        note_code = 4'd9;
        key_down = 1'b1;
        for (int k = 1; k <= 13; k++)
            wr_check(att_lvl(0, k), att_st(0, k), (k == 1) ? PH_CLR : PH_ADV, "press2");
        key_down = 1'b0;
        for (int j = 1; j <= 2; j++)
            wr_check(rel_lvl(104, j), rel_st(104, j),
                     (rel_lvl(104, j - 1) > 0) ? PH_ADV : PH_HOLD, "release2");
        base = rel_lvl(104, 2);
        key_down = 1'b1;
        wr_check(att_lvl(base, 1), att_st(base, 1), (base > 0) ? PH_ADV : PH_CLR, "repress_first");
        for (int k = 2; k <= 45; k++)
            wr_check(att_lvl(base, k), att_st(base, k), PH_ADV, "repress");
        key_down = 1'b0;
        for (int j = 1; j <= 130; j++)
            wr_check(rel_lvl(255, j), rel_st(255, j),
                     (rel_lvl(255, j - 1) > 0) ? PH_ADV : PH_HOLD, "release3");

        // Rest code: envelope runs but output stays silent.
        note_code = 4'd12;
        inc = 24'd0;
        key_down = 1'b1;
        for (int k = 1; k <= 3; k++)
            wr_check(0, att_st(0, k), (k == 1) ? PH_CLR : PH_ADV, "rest_press");
        key_down = 1'b0;
        for (int j = 1; j <= 14; j++)
            wr_check(0, rel_st(att_lvl(0, 3), j), PH_ADV, "rest_release");

        // Reset asserted during a strobe.
        note_code = 4'd9;
        inc = 24'd153791;
        key_down = 1'b1;
        wr_check(att_lvl(0, 1), att_st(0, 1), PH_CLR, "pre_reset");
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (write_audio_out === 1'b1) got = 1'b1;
        end
        chk("midstrobe_found", {31'd0, got}, 32'd1);
        reset = 1'b1;
        key_down = 1'b0;
        @(negedge clk);
        chk("midrst_write", {31'd0, write_audio_out}, 32'd0);
        chk("midrst_left", left_out, 32'd0);
        chk("midrst_right", right_out, 32'd0);
        chk("midrst_state", {30'd0, env_state}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_hold_write", {31'd0, write_audio_out}, 32'd0);
        end
        reset = 1'b0;
        ph = 24'd0;
        wr_check(0, 0, PH_HOLD, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
